sub_bytes_pipe: RTL and testbench
=================================

# sub_bytes_pipe

Parametrised, pipelined AES SubBytes/InvSubBytes engine. Substitutes `LANES` bytes per beat through the forward or inverse AES S-box, selected per beat. Two register stages with a valid/ready handshake on both sides. Sits between the round-state register and ShiftRows in the round datapath, and is reused by key expansion with `LANES=4`.

## Interface
Parameters:
- `LANES`, 16, number of byte lanes per beat; legal range 1..32.
- `TAG_W`, 4, width of an opaque sideband tag carried alongside each beat; legal range 1..16.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `in_valid` in 1: input beat present.
- `in_ready` out 1: block accepts the beat this cycle.
- `in_inv` in 1: 0 selects the forward S-box, 1 selects the inverse S-box.
- `in_tag` in `TAG_W`: sideband tag, passed through unchanged.
- `in_data` in `8*LANES`: lane k is bits `[8k+7:8k]`.
- `out_valid` out 1: output beat present.
- `out_ready` in 1: downstream accepts the output beat.
- `out_inv` out 1: mode bit of the output beat.
- `out_tag` out `TAG_W`: tag of the output beat.
- `out_data` out `8*LANES`: substituted bytes, same lane ordering as `in_data`.
- `busy` out 1: `s1_valid | s2_valid`.

## Operation
- Stage S1 registers the raw input: `s1_valid`, `s1_inv`, `s1_tag`, `s1_data`.
- S1 output feeds LANES parallel lookup instances, each selecting forward or inverse by `s1_inv`.
- Stage S2 registers the lookup results: `s2_valid`, `s2_inv`, `s2_tag`, `s2_data`. S2 drives the `out_*` ports directly.
- Advance rules:
  - `s2_adv = !s2_valid | out_ready`.
  - `s1_adv = !s1_valid | s2_adv`.
  - `in_ready = s1_adv`.
- The `out_ready` → `in_ready` combinational path is intentional. No skid buffer is used.
- S1 loads when `s1_adv`: it takes the input beat if `in_valid`, otherwise it becomes empty. S2 loads in the same way from S1 when `s2_adv`.
- Transfer rule:
  - An input transfer happens on `in_valid & in_ready`.
  - An output transfer happens on `out_valid & out_ready`.
  - Beats are never dropped, duplicated or reordered.
- Mode is per beat. Alternating `in_inv` on back-to-back beats is legal and causes no bubble.
- Stall: while `out_valid & !out_ready`, `out_data`, `out_tag` and `out_inv` hold stable. S1 still accepts one beat if it is empty.
- Full: when both stages are valid and `out_ready=0`, `in_ready=0`.
- Simultaneous pop and push with both stages full: S2 takes S1 and S1 takes the new beat in the same cycle, so throughput is 1 beat/cycle.
- Reset (`!rst_n` at an edge) clears all state:
  - `s1_valid`, `s2_valid` = 0.
  - Data, tag and mode registers = 0.
  - Therefore `out_valid=0`, `out_data=0`, `out_tag=0`, `out_inv=0`, `busy=0`.
  - `in_ready=1` from the first cycle after reset.
- Reset mid-operation discards in-flight beats. Nothing is emitted afterwards for them.
- Lookup values are the FIPS-197 S-box and its inverse. Examples: fwd(00)=63, fwd(53)=ED, fwd(FF)=16; inv(63)=00, inv(ED)=53, inv(16)=FF.

## Timing
- Latency is 2 cycles from input acceptance at edge N to `out_valid` after edge N+1, when unstalled.
- Throughput is 1 beat/cycle.
- Reset to first possible acceptance: 0 cycles after deassertion.
- Critical path: S1 register → 8-bit, 2-way table lookup → S2 register. No combinational path runs from `in_data` to `out_data`.

## Structure
- Package `aes_pkg` holds:
  - `SBOX` and `INV_SBOX` as 256×8 constant arrays.
  - The function `sbox_lookup(byte, inv)`.
  - The typedef `aes_byte_t`.
- Sub-module `aes_sbox_lut`: purely combinational, with ports `data_i[7:0]`, `inv_i`, `data_o[7:0]`. It is instantiated LANES times via generate.
- `sub_bytes_pipe` contains only the two stages, the handshake logic and the generate loop.

## Test plan
- Reset check: hold `rst_n=0` for 3 cycles with `in_valid=1`, then release. Required: `out_valid=0`, `out_data=0`, `busy=0` during reset, and `in_ready=1` on the first post-reset cycle.
- Basic forward beat: one beat, `LANES=16`, `in_data` lanes 00..0F, `in_inv=0`, `in_tag=5`, `out_ready=1`. Required: `out_valid` exactly 2 cycles later, lanes 63 7C 77 7B F2 6B 6F C5 30 01 67 2B FE D7 AB 76, `out_tag=5`.
- Round trip: stream all 256 values with `in_inv=0`, feed the outputs back with `in_inv=1`. Required: each original byte is recovered and each beat's tag is preserved.
- Back-to-back mixed modes: beats alternating {53, fwd} and {ED, inv}. Required: output bytes ED, 53, ED, 53… at 1 beat/cycle with no bubbles.
- Backpressure: `out_ready=0` for 5 cycles while pushing 4 beats. Required:
  - Exactly 2 beats are accepted, then `in_ready=0`.
  - `out_data` is stable while stalled.
  - After `out_ready=1`, all 4 beats emerge in order.
  - Random `out_ready` at 50% produces no loss.
- Reset mid-stream: assert `rst_n=0` with both stages full. Required: `out_valid=0` on the next cycle, no stale beat emerges after release, and `LANES=4` repeats pass.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES byte type, FIPS-197 S-box tables and lookup helper
package aes_pkg;
  typedef logic [7:0] aes_byte_t;
  localparam aes_byte_t SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  localparam aes_byte_t INV_SBOX [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };
  function automatic aes_byte_t sbox_lookup(input aes_byte_t b, input logic inv);
    return inv ? INV_SBOX[b] : SBOX[b];
  endfunction
endpackage

// File: rtl/aes_sbox_lut.sv
// aes_sbox_lut: combinational forward/inverse AES S-box for one byte
module aes_sbox_lut
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  input  logic       inv_i,
  output logic [7:0] data_o
);
  // table lookup, direction chosen per byte
  always_comb data_o = sbox_lookup(data_i, inv_i);
endmodule

// File: rtl/sub_bytes_pipe.sv
// sub_bytes_pipe: two-stage valid/ready SubBytes/InvSubBytes over LANES bytes
module sub_bytes_pipe
  import aes_pkg::*;
#(
  parameter int LANES = 16,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inv,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic [8*LANES-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_inv,
  output logic [TAG_W-1:0]   out_tag,
  output logic [8*LANES-1:0] out_data,
  output logic               busy
);
  logic               s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic               s1_inv_q, s1_inv_d, s2_inv_q, s2_inv_d;
  logic [TAG_W-1:0]   s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
  logic [8*LANES-1:0] s1_data_q, s1_data_d, s2_data_q, s2_data_d;
  logic [8*LANES-1:0] lut_data;
  logic               s1_adv, s2_adv, s1_load, s2_load;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_sbox_lut u_lut (
      .data_i(s1_data_q[8*l+:8]),
      .inv_i (s1_inv_q),
      .data_o(lut_data[8*l+:8])
    );
  end
  // handshake: a stage advances when empty or its successor advances; payload only loads on a real beat
  always_comb begin
    s2_adv     = !s2_valid_q | out_ready;
    s1_adv     = !s1_valid_q | s2_adv;
    s1_load    = s1_adv & in_valid;
    s2_load    = s2_adv & s1_valid_q;
    s1_valid_d = s1_adv ? in_valid : s1_valid_q;
    s1_inv_d   = s1_load ? in_inv : s1_inv_q;
    s1_tag_d   = s1_load ? in_tag : s1_tag_q;
    s1_data_d  = s1_load ? in_data : s1_data_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    s2_inv_d   = s2_load ? s1_inv_q : s2_inv_q;
    s2_tag_d   = s2_load ? s1_tag_q : s2_tag_q;
    s2_data_d  = s2_load ? lut_data : s2_data_q;
  end
  // pipeline registers, cleared by synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_inv_q   <= 1'b0;
      s1_tag_q   <= '0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_inv_q   <= 1'b0;
      s2_tag_q   <= '0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_inv_q   <= s1_inv_d;
      s1_tag_q   <= s1_tag_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_inv_q   <= s2_inv_d;
      s2_tag_q   <= s2_tag_d;
      s2_data_q  <= s2_data_d;
    end
  end
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign out_inv   = s2_inv_q;
  assign out_tag   = s2_tag_q;
  assign out_data  = s2_data_q;
  assign busy      = s1_valid_q | s2_valid_q;
endmodule

// File: tb/tb_sub_bytes_pipe.sv
// tb_sub_bytes_pipe: scoreboard bench for sub_bytes_pipe (LANES=16 and LANES=4 side by side)
module tb_sub_bytes_pipe;
  typedef struct {
    logic [127:0] d;
    logic [3:0]   tag;
    logic         inv;
    bit           chk;
    bit           cap;
    bit           lat;
    int           acc;
  } exp_t;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_inv = 1'b0;
  logic [3:0]   in_tag = '0;
  logic [127:0] in_data = '0;
  logic         out_ready = 1'b1;
  logic         in_ready, out_valid, out_inv, busy;
  logic [3:0]   out_tag;
  logic [127:0] out_data;
  logic         in_ready4, out_valid4, out_inv4, busy4;
  logic [3:0]   out_tag4;
  logic [31:0]  out_data4;
  int           n_tests = 0;
  int           n_fail = 0;
  int           cyc = 0;
  exp_t         q[$];
  exp_t         q4[$];
  logic [127:0] cap[$];
  exp_t         me, me4;

  sub_bytes_pipe #(.LANES(16), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
    .in_tag(in_tag), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_inv(out_inv), .out_tag(out_tag), .out_data(out_data), .busy(busy)
  );
  sub_bytes_pipe #(.LANES(4), .TAG_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .in_inv(in_inv),
    .in_tag(in_tag), .in_data(in_data[31:0]), .out_valid(out_valid4), .out_ready(out_ready),
    .out_inv(out_inv4), .out_tag(out_tag4), .out_data(out_data4), .busy(busy4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // call right after a negedge; returns at the negedge after the beat was accepted
  task automatic send(input logic [127:0] d, input logic inv, input logic [3:0] tag,
                      input logic [127:0] e, input bit c, input bit cp, input bit lt, output int waits);
    exp_t x;
    in_valid = 1'b1; in_data = d; in_inv = inv; in_tag = tag; waits = 0;
    #2;
    while (!in_ready && waits < 100) begin
      @(negedge clk); #2; waits++;
    end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0 for tag %0d", tag);
    end else begin
      x = '{d: e, tag: tag, inv: inv, chk: c, cap: cp, lat: lt, acc: cyc + 1};
      q.push_back(x);
      q4.push_back(x);
    end
    @(negedge clk);
  endtask

  // monitor: pop and compare whenever an output transfer is about to happen
  initial forever begin
    @(negedge clk); #3;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_out16: got %h with no beat pending", out_data);
      end else begin
        me = q.pop_front();
        if (me.chk) chk("data16", out_data, me.d);
        chk("tag16", 128'(out_tag), 128'(me.tag));
        chk("inv16", 128'(out_inv), 128'(me.inv));
        if (me.lat) chk("latency16", 128'(cyc), 128'(me.acc + 1));
        if (me.cap) cap.push_back(out_data);
      end
    end
    if (rst_n && out_valid4 && out_ready) begin
      if (q4.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_out4: got %h with no beat pending", out_data4);
      end else begin
        me4 = q4.pop_front();
        if (me4.chk) chk("data4", 128'(out_data4), 128'(me4.d[31:0]));
        chk("tag4", 128'(out_tag4), 128'(me4.tag));
      end
    end
  end

  logic [127:0] rv_in  [8] = '{{16{8'h00}}, {16{8'h53}}, {16{8'hFF}}, {16{8'h01}},
                               {16{8'h63}}, {16{8'hED}}, {16{8'h16}}, {16{8'h7C}}};
  logic [127:0] rv_out [8] = '{{16{8'h63}}, {16{8'hED}}, {16{8'h16}}, {16{8'h7C}},
                               {16{8'h00}}, {16{8'h53}}, {16{8'hFF}}, {16{8'h01}}};

  initial begin
    int w, tw, t;
    logic [127:0] d;
    // reset held with in_valid high
    rst_n = 1'b0; in_valid = 1'b1; in_data = {16{8'hA5}}; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk); #2;
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_out_data", out_data, 128'(0));
      chk("rst_busy", 128'(busy | busy4), 128'(0));
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    #2 chk("rst_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    // basic forward beat, lanes 00..0F
    send(128'h0F0E0D0C0B0A09080706050403020100, 1'b0, 4'd5,
         128'h76ABD7FE2B670130C56F6BF27B777C63, 1, 0, 1, w);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    // back-to-back alternating modes
    tw = 0;
    for (int i = 0; i < 8; i++) begin
      send((i % 2) ? {16{8'hED}} : {16{8'h53}}, 1'(i % 2), 4'(i),
           (i % 2) ? {16{8'h53}} : {16{8'hED}}, 1, 0, 1, w);
      tw += w;
    end
    in_valid = 1'b0;
    chk("mixed_no_bubble", 128'(tw), 128'(0));
    repeat (4) @(negedge clk);
    // round trip: forward all 256 values, then invert the captured results
    cap.delete();
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 16; k++) d[8*k+:8] = 8'(b * 16 + k);
      send(d, 1'b0, 4'(b), '0, 0, 1, 0, w);
    end
    in_valid = 1'b0;
    t = 0;
    while (cap.size() < 16 && t < 50) begin @(negedge clk); t++; end
    chk("rt_capture_count", 128'(cap.size()), 128'(16));
    for (int b = 0; b < 16 && b < cap.size(); b++) begin
      for (int k = 0; k < 16; k++) d[8*k+:8] = 8'(b * 16 + k);
      send(cap[b], 1'b1, 4'(b), d, 1, 0, 1, w);
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    // backpressure: only two beats fit while stalled
    out_ready = 1'b0;
    send(rv_in[0], 1'b0, 4'd1, rv_out[0], 1, 0, 0, w);
    send(rv_in[1], 1'b0, 4'd2, rv_out[1], 1, 0, 0, w);
    in_valid = 1'b1; in_data = rv_in[2]; in_inv = 1'b0; in_tag = 4'd3;
    repeat (5) begin
      #2;
      chk("bp_in_ready", 128'({in_ready, in_ready4}), 128'(0));
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      chk("bp_out_data_hold", out_data, rv_out[0]);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(rv_in[2], 1'b0, 4'd3, rv_out[2], 1, 0, 0, w);
    send(rv_in[3], 1'b0, 4'd4, rv_out[3], 1, 0, 0, w);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    // random out_ready at 50%
    fork
      for (int i = 0; i < 24; i++)
        send(rv_in[i % 8], 1'(i % 8 >= 4), 4'(i), rv_out[i % 8], 1, 0, 0, w);
      begin
        repeat (40) begin @(negedge clk); out_ready = 1'($urandom_range(0, 1)); end
        out_ready = 1'b1;
      end
    join
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("rand_drained", 128'(q.size() + q4.size()), 128'(0));
    // reset with both stages full
    out_ready = 1'b0;
    send(rv_in[4], 1'b1, 4'd9, rv_out[4], 1, 0, 0, w);
    send(rv_in[5], 1'b1, 4'd10, rv_out[5], 1, 0, 0, w);
    in_valid = 1'b0;
    rst_n = 1'b0;
    q.delete(); q4.delete();
    @(negedge clk); #2;
    chk("mid_rst_out_valid", 128'({out_valid, out_valid4}), 128'(0));
    chk("mid_rst_busy", 128'({busy, busy4}), 128'(0));
    chk("mid_rst_out_data", out_data, 128'(0));
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #2 chk("mid_rst_in_ready", 128'({in_ready, in_ready4}), 128'(3));
    repeat (5) @(negedge clk);
    for (int i = 0; i < 4; i++)
      send(rv_in[i + 4], 1'b1, 4'(i + 11), rv_out[i + 4], 1, 0, 1, w);
    in_valid = 1'b0;
    t = 0;
    while ((q.size() != 0 || q4.size() != 0) && t < 50) begin @(negedge clk); t++; end
    chk("final_drained", 128'(q.size() + q4.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
